// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register and its helpers:
// mode encoding and the mode type.
package univ_shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHL  = 2'b01;
    localparam mode_t MODE_SHR  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    // True for either shift direction; both advance the frame counter.
    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shift operations modulo WIDTH and emits a registered one-cycle
// frame_done pulse on each wrap. Reusable by any serializer.
module shift_frame_counter #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (inc) begin
            if (shift_cnt == LAST) begin
                shift_cnt  <= '0;
                frame_done <= 1'b1;
            end else begin
                shift_cnt  <= shift_cnt + CNT_W'(1);
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold / shift-left / shift-right /
// parallel load. Define UNIV_SHIFT_REG_ROTATE_EN to add the rotate input.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rotate,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    mode_t            mode_r;
    logic [WIDTH-1:0] q_next;
    logic             so_next;
    logic             fill_lsb;
    logic             fill_msb;
    logic             cnt_inc;
    logic             cnt_clr;

    assign mode_r = mode_t'(mode);

    // Bits entering the register on a shift: serial input, or the outgoing
    // bit when rotating.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign fill_lsb = rotate ? q[WIDTH-1] : sin_lsb;
    assign fill_msb = rotate ? q[0]       : sin_msb;
`else
    assign fill_lsb = sin_lsb;
    assign fill_msb = sin_msb;
`endif

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        q_next  = q;
        so_next = serial_out;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (en) begin
            unique case (mode_r)
                MODE_SHL: begin
                    q_next  = {q[WIDTH-2:0], fill_lsb};
                    so_next = q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next  = {fill_msb, q[WIDTH-1:1]};
                    so_next = q[0];
                end
                MODE_LOAD: begin
                    q_next  = d;
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
            cnt_inc = is_shift(mode_r);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            serial_out <= 1'b0;
        end else begin
            q          <= q_next;
            serial_out <= so_next;
        end
    end

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

endmodule
